// File: rtl/profiler_pkg.sv
// Shared types and defaults for the store-port cycle profiler.
package profiler_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DONE = 2'd1,
        ST_DUMP = 2'd2
    } state_t;

    localparam logic [1:0] KIND_RESULT = 2'd0;
    localparam logic [1:0] KIND_CYCLE  = 2'd1;
    localparam logic [1:0] KIND_TOTAL  = 2'd2;

    localparam int N_SEG_DEFAULT       = 20;
    localparam int CW_DEFAULT          = 32;
    localparam int RESULT_BASE_DEFAULT = 80;

endpackage

// File: rtl/dump_sequencer.sv
// Walks the dump beats (results, cycle counts, total) and holds each beat
// until the reader accepts it.
module dump_sequencer
    import profiler_pkg::*;
#(
    parameter int N_SEG = N_SEG_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_ready,
    output logic       o_valid,
    output logic [1:0] o_kind,
    output logic [4:0] o_idx,
    output logic       o_last
);

    localparam logic [4:0] LAST_IDX = 5'(N_SEG - 1);

    logic       r_valid;
    logic [1:0] r_kind;
    logic [4:0] r_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_kind  <= KIND_RESULT;
            r_idx   <= 5'd0;
        end else if (i_start && !r_valid) begin
            r_valid <= 1'b1;
            r_kind  <= KIND_RESULT;
            r_idx   <= 5'd0;
        end else if (r_valid && i_ready) begin
            if (r_kind == KIND_TOTAL) begin
                r_valid <= 1'b0;
                r_kind  <= KIND_RESULT;
                r_idx   <= 5'd0;
            end else if (r_idx == LAST_IDX) begin
                r_kind <= (r_kind == KIND_RESULT) ? KIND_CYCLE : KIND_TOTAL;
                r_idx  <= 5'd0;
            end else begin
                r_idx <= r_idx + 5'd1;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_kind  = r_kind;
    assign o_idx   = r_idx;
    assign o_last  = r_valid && i_ready && (r_kind == KIND_TOTAL);

endmodule

// File: rtl/store_cycle_profiler.sv
// Per-segment cycle profiler on the data-memory store port, with result
// capture and a valid/ready replay stream.
//   state | meaning
//   RUN   | counting cycles; each store closes a segment
//   DONE  | all segments closed, data frozen, waiting for dump_start
//   DUMP  | replaying results, cycle counts and total
module store_cycle_profiler
    import profiler_pkg::*;
#(
    parameter int N_SEG       = N_SEG_DEFAULT,
    parameter int CW          = CW_DEFAULT,
    parameter int RESULT_BASE = RESULT_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data,
    input  logic        dump_start,
    input  logic        dump_ready,
    output logic        dump_valid,
    output logic [1:0]  dump_kind,
    output logic [4:0]  dump_idx,
    output logic [31:0] dump_data,
    output logic [4:0]  seg_idx,
    output logic        done,
    output logic        overflow
);

    localparam logic [31:0] WIN_LO   = 32'(RESULT_BASE);
    localparam logic [31:0] WIN_HI   = 32'(RESULT_BASE + 4 * N_SEG);
    localparam logic [4:0]  LAST_SEG = 5'(N_SEG - 1);

    state_t         r_state;
    logic [4:0]     r_seg_idx;
    logic           r_done;
    logic           r_overflow;
    logic [CW-1:0]  r_total;
    logic [CW-1:0]  r_cyc    [N_SEG];
    logic [31:0]    r_result [N_SEG];

    logic           w_in_window;
    logic [4:0]     w_slot;
    logic           w_start;
    logic           w_valid;
    logic [1:0]     w_kind;
    logic [4:0]     w_idx;
    logic           w_last;
    logic [31:0]    w_payload;

    assign w_in_window = (alu_result >= WIN_LO) && (alu_result < WIN_HI)
                         && (alu_result[1:0] == 2'b00);
    assign w_slot      = 5'((alu_result - WIN_LO) >> 2);
    assign w_start     = (r_state == ST_DONE) && dump_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_seg_idx  <= 5'd0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_total    <= '0;
            for (int i = 0; i < N_SEG; i++) begin
                r_cyc[i]    <= '0;
                r_result[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    // the store cycle itself is charged to the segment it closes
                    if (r_cyc[r_seg_idx] != '1)
                        r_cyc[r_seg_idx] <= r_cyc[r_seg_idx] + CW'(1);
                    if (r_total != '1)
                        r_total <= r_total + CW'(1);
                    if (mem_write) begin
                        if (w_in_window)
                            r_result[w_slot] <= write_data;
                        r_seg_idx <= r_seg_idx + 5'd1;
                        if (r_seg_idx == LAST_SEG) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (mem_write)
                        r_overflow <= 1'b1;
                    if (dump_start)
                        r_state <= ST_DUMP;
                end
                ST_DUMP: begin
                    if (mem_write)
                        r_overflow <= 1'b1;
                    if (w_last)
                        r_state <= ST_DONE;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    dump_sequencer #(.N_SEG(N_SEG)) u_seq (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_start),
        .i_ready (dump_ready),
        .o_valid (w_valid),
        .o_kind  (w_kind),
        .o_idx   (w_idx),
        .o_last  (w_last)
    );

    always_comb begin
        w_payload = '0;
        if (w_valid) begin
            case (w_kind)
                KIND_RESULT: w_payload = r_result[w_idx];
                KIND_CYCLE:  w_payload = 32'(r_cyc[w_idx]);
                KIND_TOTAL:  w_payload = 32'(r_total);
                default:     w_payload = '0;
            endcase
        end
    end

    assign dump_valid = w_valid;
    assign dump_kind  = w_kind;
    assign dump_idx   = w_idx;
    assign dump_data  = w_payload;
    assign seg_idx    = r_seg_idx;
    assign done       = r_done;
    assign overflow   = r_overflow;

endmodule
